// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber client datapath: word width, maximum
// public-key length, the per-security-level key length and the feeder
// state encoding.
package kyber_pkg;

  localparam int KYBER_WORD_W       = 32;
  localparam int KYBER_PK_WORDS_MAX = 392;
  localparam int KYBER_CNT_W        = 9;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    LOAD   = 3'd1,
    FULL   = 3'd2,
    STREAM = 3'd3,
    ERR    = 3'd4
  } feeder_state_t;

  // Public key length in words for security level k: 96*k + 8.
  // Evaluated in 9 bits; results are only meaningful for legal k.
  function automatic logic [KYBER_CNT_W-1:0] pk_words(input logic [2:0] k);
    logic [KYBER_CNT_W-1:0] kk;
    kk = {6'd0, k};
    return KYBER_CNT_W'((kk * 9'd96) + 9'd8);
  endfunction

  // Only k = 2, 3 and 4 are defined Kyber security levels.
  function automatic logic k_legal(input logic [2:0] k);
    return (k == 3'd2) || (k == 3'd3) || (k == 3'd4);
  endfunction

endpackage

// File: rtl/kyber_word_ram.sv
// Simple dual-port synchronous word RAM: one write port and one read port
// with a registered output. The array itself is never reset so it maps
// onto a block RAM.
module kyber_word_ram #(
  parameter int WORD_W = 32,
  parameter int AW     = 9,
  parameter int DEPTH  = 2 ** AW
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered output, one cycle of latency, holds when idle.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kyber_pk_feeder.sv
// Public-key feeder: buffers a key written word-by-word by the host and,
// on each fresh rising edge of req_pk_i, replays it to the client core as
// a gap-free valid-qualified word stream. The key stays buffered until
// clear_i or reset so it can be replayed for repeated encapsulations.
module kyber_pk_feeder
  import kyber_pkg::*;
#(
  parameter int WORD_W = KYBER_WORD_W,
  parameter int DEPTH  = KYBER_PK_WORDS_MAX,
  parameter int AW     = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        k_i,
  input  logic              clear_i,
  input  logic              host_wr_en_i,
  input  logic [WORD_W-1:0] host_wr_data_i,
  output logic              host_ready_o,
  output logic              loaded_o,
  output logic              err_o,
  input  logic              req_pk_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] dout_o
);

  feeder_state_t          state_q, state_d;
  logic [KYBER_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [KYBER_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [2:0]             k_lat_q, k_lat_d;
  logic                   err_q, err_d;
  logic                   req_q;
  logic                   rd_pend_q, rd_pend_d;
  logic                   valid_q;
  logic [WORD_W-1:0]      dout_q;

  logic                   req_rise;
  logic [KYBER_CNT_W-1:0] words;
  logic                   ram_we;
  logic [AW-1:0]          ram_waddr;
  logic                   ram_re;
  logic [AW-1:0]          ram_raddr;
  logic [WORD_W-1:0]      ram_rdata;

  assign req_rise = req_pk_i & ~req_q;
  assign words    = pk_words(k_lat_q);

  // State register and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      k_lat_q   <= '0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      k_lat_q   <= k_lat_d;
      err_q     <= err_d;
      req_q     <= req_pk_i;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next-state logic plus RAM port control; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    k_lat_d   = k_lat_q;
    err_d     = err_q;
    rd_pend_d = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = AW'(wr_cnt_q);
    ram_re    = 1'b0;
    ram_raddr = AW'(rd_cnt_q);

    if (clear_i) begin
      state_d  = EMPTY;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (host_wr_en_i) begin
            k_lat_d = k_i;
            if (!k_legal(k_i)) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              ram_we    = 1'b1;
              ram_waddr = '0;
              wr_cnt_d  = KYBER_CNT_W'(1);
              state_d   = LOAD;
            end
          end
        end
        LOAD: begin
          if (host_wr_en_i) begin
            ram_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + KYBER_CNT_W'(1);
            if (wr_cnt_d == words) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (req_rise) begin
            ram_re    = 1'b1;
            ram_raddr = '0;
            rd_cnt_d  = KYBER_CNT_W'(1);
            rd_pend_d = 1'b1;
            state_d   = STREAM;
          end
        end
        STREAM: begin
          if (rd_cnt_q != words) begin
            ram_re    = 1'b1;
            rd_cnt_d  = rd_cnt_q + KYBER_CNT_W'(1);
            rd_pend_d = 1'b1;
          end else if (!rd_pend_q) begin
            rd_cnt_d = '0;
            state_d  = FULL;
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Output stage: registers the RAM word and its valid flag one cycle after each read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= rd_pend_q & ~clear_i;
      if (rd_pend_q && !clear_i) begin
        dout_q <= ram_rdata;
      end
    end
  end

  kyber_word_ram #(
    .WORD_W (WORD_W),
    .AW     (AW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we & ~rst_i),
    .waddr_i (ram_waddr),
    .wdata_i (host_wr_data_i),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign host_ready_o = (state_q == EMPTY) || (state_q == LOAD);
  assign loaded_o     = (state_q == FULL);
  assign err_o        = err_q;
  assign valid_o      = valid_q;
  assign dout_o       = dout_q;

endmodule

// File: tb/tb_kyber_pk_feeder.sv
// Directed bench for kyber_pk_feeder: loads keys at each security level,
// streams them against a scoreboard queue of expected words, and exercises
// illegal k, clear during a stream and reset during a stream.
module tb_kyber_pk_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  kIn;
  logic        clearIn;
  logic        hostWrEn;
  logic [31:0] hostWrData;
  logic        hostReady;
  logic        loaded;
  logic        err;
  logic        reqPk;
  logic        valid;
  logic [31:0] dout;

  logic [31:0] model [392];
  logic [31:0] sb [$];
  int total = 0;
  int bad   = 0;

  kyber_pk_feeder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .k_i            (kIn),
    .clear_i        (clearIn),
    .host_wr_en_i   (hostWrEn),
    .host_wr_data_i (hostWrData),
    .host_ready_o   (hostReady),
    .loaded_o       (loaded),
    .err_o          (err),
    .req_pk_i       (reqPk),
    .valid_o        (valid),
    .dout_o         (dout)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearPulse();
    clearIn = 1'b1;
    tick();
    clearIn = 1'b0;
    check("clearValid", valid, 1'b0);
    check("clearLoaded", loaded, 1'b0);
    check("clearReady", hostReady, 1'b1);
    check("clearErr", err, 1'b0);
  endtask

  task automatic loadKey(input logic [2:0] kVal, input logic [31:0] base, input int n,
                         input logic [2:0] kLater);
    kIn = kVal;
    for (int i = 0; i < n; i++) begin
      model[i]   = base + i;
      hostWrEn   = 1'b1;
      hostWrData = base + i;
      if (i == n - 1) begin
        check("loadedBeforeLast", loaded, 1'b0);
        check("readyBeforeLast", hostReady, 1'b1);
      end
      tick();
      kIn = kLater;
    end
    hostWrEn = 1'b0;
    check("loadedAfterLast", loaded, 1'b1);
    check("readyAfterLast", hostReady, 1'b0);
  endtask

  task automatic runStream(input int words, input bit holdReq);
    int firstT, lastT, nValid;
    logic [31:0] exp;
    firstT = -1;
    lastT  = -1;
    nValid = 0;
    for (int i = 0; i < words; i++) sb.push_back(model[i]);
    reqPk = 1'b1;
    for (int t = 0; t < words + 4; t++) begin
      tick();
      if (t == 0) reqPk = holdReq;
      if (valid) begin
        if (firstT < 0) firstT = t;
        lastT = t;
        nValid++;
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          check("streamDout", dout, exp);
        end
      end
    end
    check("streamFirst", firstT, 1);
    check("streamCount", nValid, words);
    check("streamLast", lastT, words);
    check("streamLeftover", sb.size(), 0);
    check("streamLoaded", loaded, 1'b1);
    sb.delete();
  endtask

  task automatic runPartial(input int stopWord);
    bit reached;
    logic [31:0] exp;
    reached = 1'b0;
    for (int i = 0; i <= stopWord; i++) sb.push_back(model[i]);
    reqPk = 1'b1;
    tick();
    reqPk = 1'b0;
    for (int t = 0; t < stopWord + 4 && !reached; t++) begin
      tick();
      if (valid && sb.size() > 0) begin
        exp = sb.pop_front();
        check("partialDout", dout, exp);
        check("partialLoaded", loaded, 1'b0);
        reached = (sb.size() == 0);
      end
    end
    check("partialReached", reached, 1'b1);
    sb.delete();
  endtask

  task automatic countIdleValid(input string tag, input int cycles);
    int n;
    n = 0;
    for (int t = 0; t < cycles; t++) begin
      tick();
      if (valid) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    rst        = 1'b1;
    kIn        = 3'd0;
    clearIn    = 1'b0;
    hostWrEn   = 1'b0;
    hostWrData = '0;
    reqPk      = 1'b0;
    for (int i = 0; i < 392; i++) model[i] = '0;

    // Reset values.
    tick();
    tick();
    check("rstReady", hostReady, 1'b1);
    check("rstLoaded", loaded, 1'b0);
    check("rstValid", valid, 1'b0);
    check("rstDout", dout, 32'h0);
    check("rstErr", err, 1'b0);
    rst = 1'b0;
    tick();

    // k=2, k changed to an illegal value after latching must be ignored.
    loadKey(3'd2, 32'h1000_0000, 200, 3'd7);
    runStream(200, 1'b0);
    clearPulse();

    // k=4 with extra writes after the buffer is full.
    loadKey(3'd4, 32'h4000_0000, 392, 3'd4);
    for (int j = 0; j < 5; j++) begin
      hostWrEn   = 1'b1;
      hostWrData = 32'hDEAD_0000 + j;
      tick();
      check("extraReady", hostReady, 1'b0);
    end
    hostWrEn = 1'b0;
    check("extraLoaded", loaded, 1'b1);
    runStream(392, 1'b0);
    check("k4LastDout", dout, model[391]);
    clearPulse();

    // k=3, held request must not retrigger; a fresh rise replays.
    loadKey(3'd3, 32'h3000_0000, 296, 3'd3);
    runStream(296, 1'b1);
    countIdleValid("heldReqNoStream", 20);
    reqPk = 1'b0;
    tick();
    runStream(296, 1'b0);

    // Illegal k on the first write.
    clearPulse();
    kIn        = 3'd5;
    hostWrEn   = 1'b1;
    hostWrData = 32'hBAD0_0000;
    tick();
    check("errSet", err, 1'b1);
    check("errReady", hostReady, 1'b0);
    check("errLoaded", loaded, 1'b0);
    kIn = 3'd2;
    tick();
    hostWrEn = 1'b0;
    check("errSticky", err, 1'b1);
    reqPk = 1'b1;
    countIdleValid("errNoStream", 5);
    reqPk = 1'b0;
    clearPulse();
    loadKey(3'd2, 32'h2000_0000, 200, 3'd2);
    runStream(200, 1'b0);

    // clear at word 100 of a k=3 stream, then a full reload and stream.
    clearPulse();
    loadKey(3'd3, 32'h5000_0000, 296, 3'd3);
    runPartial(100);
    clearPulse();
    loadKey(3'd3, 32'h6000_0000, 296, 3'd3);
    runStream(296, 1'b0);

    // Reset in the middle of a stream.
    runPartial(50);
    #1;
    rst = 1'b1;
    #1;
    check("midRstValid", valid, 1'b0);
    check("midRstDout", dout, 32'h0);
    check("midRstReady", hostReady, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    check("postRstReady", hostReady, 1'b1);
    check("postRstLoaded", loaded, 1'b0);
    reqPk = 1'b1;
    countIdleValid("postRstNoStream", 20);
    reqPk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
